// File: rtl/trap_ctrl_if.sv
// Commit-stage / CSR-file bundle for the machine-mode trap sequencer.
// The master side is the pipeline and CSR file; the slave side is trap_ctrl.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic [XLEN-1:0] i_pc;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_badaddr;
  logic            i_ex_inst_illegal;
  logic            i_ex_inst_addr;
  logic            i_ex_ebreak;
  logic            i_ex_ecall;
  logic            i_ex_ld_addr;
  logic            i_ex_st_addr;
  logic            i_mret;
  logic            i_mie;
  logic            i_meie;
  logic            i_msie;
  logic            i_mtie;
  logic            i_meip;
  logic            i_msip;
  logic            i_mtip;
  logic [XLEN-1:0] i_mtvec;
  logic [XLEN-1:0] i_mepc;
  logic            i_drain_done;
  logic            i_redirect_ack;

  logic            o_stall;
  logic            o_flush;
  logic            o_trap_we;
  logic [XLEN-1:0] o_mepc_wd;
  logic [XLEN-1:0] o_mcause_wd;
  logic [XLEN-1:0] o_mtval_wd;
  logic            o_push_mstatus;
  logic            o_pop_mstatus;
  logic            o_redirect;
  logic [XLEN-1:0] o_redirect_pc;
  logic            o_busy;

  modport master (
    output i_valid, i_pc, i_inst, i_badaddr,
           i_ex_inst_illegal, i_ex_inst_addr, i_ex_ebreak, i_ex_ecall,
           i_ex_ld_addr, i_ex_st_addr, i_mret,
           i_mie, i_meie, i_msie, i_mtie, i_meip, i_msip, i_mtip,
           i_mtvec, i_mepc, i_drain_done, i_redirect_ack,
    input  o_stall, o_flush, o_trap_we, o_mepc_wd, o_mcause_wd, o_mtval_wd,
           o_push_mstatus, o_pop_mstatus, o_redirect, o_redirect_pc, o_busy
  );

  modport slave (
    input  i_valid, i_pc, i_inst, i_badaddr,
           i_ex_inst_illegal, i_ex_inst_addr, i_ex_ebreak, i_ex_ecall,
           i_ex_ld_addr, i_ex_st_addr, i_mret,
           i_mie, i_meie, i_msie, i_mtie, i_meip, i_msip, i_mtip,
           i_mtvec, i_mepc, i_drain_done, i_redirect_ack,
    output o_stall, o_flush, o_trap_we, o_mepc_wd, o_mcause_wd, o_mtval_wd,
           o_push_mstatus, o_pop_mstatus, o_redirect, o_redirect_pc, o_busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks interrupt > exception > MRET on a valid
// commit, then walks the pipeline through flush, drain, CSR commit and redirect.
module trap_ctrl #(
  parameter int XLEN = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  trap_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DRAIN    = 2'd1;
  localparam logic [1:0] S_COMMIT   = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_INT  = 2'd1;
  localparam logic [1:0] K_EXC  = 2'd2;
  localparam logic [1:0] K_RET  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [1:0]      kind_q, kind_d;
  logic [XLEN-1:0] mepc_q, mcause_q, mtval_q, target_q;
  logic [XLEN-1:0] mepc_d, mcause_d, mtval_d, target_d;
  logic            flush_q;

  logic            irq_e, irq_s, irq_t;
  logic            take_int, take_exc, take_ret, accept;
  logic [3:0]      code;
  logic [XLEN-1:0] base;

  // Only the word-aligned part of mepc forms the return target.
  logic unused_mepc_lsb;
  assign unused_mepc_lsb = ^bus.i_mepc[1:0];

  always_comb begin
    irq_e    = bus.i_meie & bus.i_meip;
    irq_s    = bus.i_msie & bus.i_msip;
    irq_t    = bus.i_mtie & bus.i_mtip;
    take_int = bus.i_mie & (irq_e | irq_s | irq_t);
    take_exc = bus.i_ex_inst_addr | bus.i_ex_inst_illegal | bus.i_ex_ebreak |
               bus.i_ex_ecall | bus.i_ex_ld_addr | bus.i_ex_st_addr;
    take_ret = bus.i_mret;
    // Gated by reset so every output reads zero while reset is held.
    accept   = i_rst & (state_q == S_IDLE) & bus.i_valid &
               (take_int | take_exc | take_ret);
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    code    = 4'd0;
    mtval_d = '0;
    if (take_int) begin
      if (irq_e)      code = 4'd11;
      else if (irq_s) code = 4'd3;
      else            code = 4'd7;
    end else if (bus.i_ex_inst_addr) begin
      code    = 4'd0;
      mtval_d = bus.i_badaddr;
    end else if (bus.i_ex_inst_illegal) begin
      code    = 4'd2;
      mtval_d = XLEN'(bus.i_inst);
    end else if (bus.i_ex_ebreak) begin
      code    = 4'd3;
      mtval_d = bus.i_pc;
    end else if (bus.i_ex_ecall) begin
      code    = 4'd11;
    end else if (bus.i_ex_ld_addr) begin
      code    = 4'd4;
      mtval_d = bus.i_badaddr;
    end else if (bus.i_ex_st_addr) begin
      code    = 4'd6;
      mtval_d = bus.i_badaddr;
    end

    mepc_d             = bus.i_pc;
    mcause_d           = XLEN'(code);
    mcause_d[XLEN-1]   = take_int;
    base               = {bus.i_mtvec[XLEN-1:2], 2'b00};

    if (take_int)      kind_d = K_INT;
    else if (take_exc) kind_d = K_EXC;
    else               kind_d = K_RET;

    if (kind_d == K_RET)
      target_d = {bus.i_mepc[XLEN-1:2], 2'b00};
    else if (take_int && bus.i_mtvec[1:0] == 2'b01)
      target_d = base + (XLEN'(code) << 2);
    else
      target_d = base;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept)             state_d = S_DRAIN;
      S_DRAIN:    if (bus.i_drain_done)   state_d = S_COMMIT;
      S_COMMIT:                           state_d = S_REDIRECT;
      S_REDIRECT: if (bus.i_redirect_ack) state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= accept;
    end
  end

  // The latched trap fields are cleared by reset too, because they drive outputs directly.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      kind_q   <= K_NONE;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
      target_q <= '0;
    end else if (accept) begin
      kind_q   <= kind_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      target_q <= target_d;
    end
  end

  logic in_commit, is_trap;
  assign in_commit = (state_q == S_COMMIT);
  assign is_trap   = (kind_q == K_INT) | (kind_q == K_EXC);

  assign bus.o_stall        = (state_q != S_IDLE) | accept;
  assign bus.o_flush        = flush_q;
  assign bus.o_trap_we      = in_commit & is_trap;
  assign bus.o_push_mstatus = in_commit & is_trap;
  assign bus.o_pop_mstatus  = in_commit & (kind_q == K_RET);
  assign bus.o_mepc_wd      = mepc_q;
  assign bus.o_mcause_wd    = mcause_q;
  assign bus.o_mtval_wd     = mtval_q;
  assign bus.o_redirect     = (state_q == S_REDIRECT);
  assign bus.o_redirect_pc  = (state_q == S_REDIRECT) ? target_q : '0;
  assign bus.o_busy         = (state_q != S_IDLE);

endmodule
